// File: rtl/ctrl_branch_resolve_pkg.sv
// Shared types for branch resolution: address width, default queue depth,
// in-flight queue entry layout and the resolve FSM state encoding.
package ctrl_branch_resolve_pkg;

  localparam int CBR_AW    = 32;
  localparam int CBR_DEPTH = 8;

  typedef struct packed {
    logic [CBR_AW-1:0] pc;
    logic [CBR_AW-1:0] pred_pc;
    logic              pred_taken;
  } br_entry_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/ctrl_branch_fifo.sv
// In-flight branch queue: generic FIFO with synchronous clear.
// Head visible combinationally; push ignored when full, pop ignored when empty.
// Clear has priority over push and pop in the same cycle.
module ctrl_branch_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         clear,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  // Pointers are log2(DEPTH) wide so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ctrl_branch_resolve.sv
// Branch resolution: tracks predicted branches in order, checks them against execute.
// Update/flush/redirect appear one cycle after resolution; push_ready low when full or flushing.
// A mispredict or ext_flush empties the queue and drops any same-cycle push.
module ctrl_branch_resolve
  import ctrl_branch_resolve_pkg::*;
#(
  parameter int DEPTH = CBR_DEPTH,
  parameter int AW    = CBR_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_valid,
  output logic          push_ready,
  input  logic [AW-1:0] push_pc,
  input  logic [AW-1:0] push_pred_pc,
  input  logic          push_pred_taken,
  input  logic          res_valid,
  input  logic          res_taken,
  input  logic [AW-1:0] res_target,
  input  logic          ext_flush,
  output logic          upd_valid,
  output logic          upd_taken,
  output logic [AW-1:0] upd_pc,
  output logic [AW-1:0] upd_target,
  output logic          flush_o,
  output logic [AW-1:0] redirect_pc,
  output logic          err_underflow,
  output logic [31:0]   cnt_branches,
  output logic [31:0]   cnt_mispred
);

  state_t      state;
  br_entry_t   push_entry;
  br_entry_t   head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        in_run;
  logic        res_accept;
  logic        mispred;
  logic        redirect;
  logic        clear;
  logic        do_push;
  logic [AW-1:0] actual_next;

  assign in_run      = (state == ST_RUN);
  assign push_ready  = in_run && !fifo_full;
  assign res_accept  = res_valid && in_run && !fifo_empty;
  assign actual_next = res_taken ? res_target : head.pc + AW'(4);
  assign mispred     = res_accept &&
                       ((actual_next != head.pred_pc) || (res_taken != head.pred_taken));
  // A trap flush owns fetch; the mispredict still counts but does not redirect.
  assign redirect    = mispred && !ext_flush;
  assign clear       = ext_flush || mispred;
  assign do_push     = push_valid && push_ready && !clear;

  assign push_entry = '{pc: push_pc, pred_pc: push_pred_pc, pred_taken: push_pred_taken};

  ctrl_branch_fifo #(
    .W     ($bits(br_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (do_push),
    .push_data (push_entry),
    .pop       (res_accept),
    .clear     (clear),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_RUN;
      flush_o       <= 1'b0;
      redirect_pc   <= '0;
      upd_valid     <= 1'b0;
      upd_taken     <= 1'b0;
      upd_pc        <= '0;
      upd_target    <= '0;
      err_underflow <= 1'b0;
      cnt_branches  <= '0;
      cnt_mispred   <= '0;
    end else begin
      case (state)
        ST_RUN:   if (redirect) state <= ST_FLUSH;
        ST_FLUSH: state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase

      flush_o   <= redirect;
      upd_valid <= res_accept;
      if (redirect) redirect_pc <= actual_next;

      if (res_accept) begin
        upd_pc       <= head.pc;
        upd_taken    <= res_taken;
        upd_target   <= res_target;
        cnt_branches <= cnt_branches + 32'd1;
        if (mispred) cnt_mispred <= cnt_mispred + 32'd1;
      end

      if (res_valid && in_run && fifo_empty) err_underflow <= 1'b1;
    end
  end

endmodule

// File: doc/ctrl_branch_resolve.md
CTRL_BRANCH_RESOLVE -- requirements
Module: ctrl_branch_resolve

Interface
REQ-001 Parameter DEPTH, default 8, in-flight branch queue entries; power of two, >= 2.
REQ-002 Parameter AW, default 32, instruction address width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 push_valid  input  1  fetch presents a predicted branch.
REQ-006 push_ready  output  1  queue accepts push this cycle.
REQ-007 push_pc / push_pred_pc  input  AW each  branch PC; predicted next PC.
REQ-008 push_pred_taken  input  1  predicted direction.
REQ-009 res_valid  input  1  execute resolves the oldest in-flight branch, in program order.
REQ-010 res_taken / res_target  input  1 / AW  actual direction; actual taken target.
REQ-011 ext_flush  input  1  exception/trap flush; discards queue, no predictor update.
REQ-012 upd_valid / upd_taken  output  1 each  predictor update strobe; actual direction.
REQ-013 upd_pc / upd_target  output  AW each  branch PC; actual taken target.
REQ-014 flush_o / redirect_pc  output  1 / AW  mispredict flush pulse; correct fetch PC.
REQ-015 err_underflow  output  1  sticky: resolution received while queue empty.
REQ-016 cnt_branches / cnt_mispred  output  32 each  resolved-branch and mispredict counters.

Function
REQ-017 Queue SHALL be FIFO of {pc, pred_pc, pred_taken}; push on push_valid && push_ready.
REQ-018 push_ready SHALL be 1 only when state is RUN and occupancy < DEPTH; no push-while-full even if popping same cycle.
REQ-019 res_valid with non-empty queue SHALL pop head; actual_next = res_taken ? res_target : head.pc + 4 (mod 2^AW).
REQ-020 Mispredict SHALL be (actual_next != head.pred_pc) or (res_taken != head.pred_taken).
REQ-021 Every accepted resolution SHALL produce, next cycle, a one-cycle upd_valid with upd_pc=head.pc, upd_taken=res_taken, upd_target=res_target.
REQ-022 Every accepted resolution SHALL increment cnt_branches; each mispredict SHALL increment cnt_mispred; both wrap at 2^32.
REQ-023 FSM states RUN, FLUSH; RUN->FLUSH on mispredict; FLUSH->RUN unconditionally after one cycle.
REQ-024 On mispredict: queue emptied at that edge, same-cycle push discarded, next cycle flush_o=1 and redirect_pc=actual_next.
REQ-025 In FLUSH: push_ready=0, res_valid ignored (no pop, no update, no count).
REQ-026 res_valid with empty queue SHALL set err_underflow, pop nothing, produce no update.
REQ-027 ext_flush SHALL empty queue and discard same-cycle push; same-cycle resolution still produces its update and counting but no flush_o; ext_flush has priority over mispredict redirect.
REQ-028 Simultaneous push and resolve (not full, no mispredict) SHALL leave occupancy unchanged.
REQ-029 Pointers SHALL wrap modulo DEPTH; occupancy held in a log2(DEPTH)+1-bit counter.

Reset
REQ-030 rst SHALL clear pointers and occupancy, set state RUN, and drive upd_valid, upd_taken, upd_pc, upd_target, flush_o, redirect_pc, err_underflow, cnt_branches and cnt_mispred to 0.
REQ-031 rst asserted mid-operation SHALL discard all in-flight entries and any pending update or flush pulse.

Structure
REQ-032 Shared package SHALL hold AW, default DEPTH, the queue entry struct and the RUN/FLUSH state enum.
REQ-033 Queue storage/pointers SHALL be sub-module ctrl_branch_fifo (push, pop, clear, full, empty, head); resolve logic, FSM and counters stay in top.

Verification
REQ-034 Push pc=0x100 pred_pc=0x104 taken=0; resolve taken=0 -> next cycle upd_valid=1, upd_pc=0x100, upd_taken=0, flush_o=0, cnt_branches=1.
REQ-035 Push pc=0x200 pred_pc=0x204; resolve taken=1 target=0x300 -> flush_o=1, redirect_pc=0x300, queue empty, cnt_mispred=1, push_ready=0 that cycle.
REQ-036 Fill DEPTH=8 entries -> push_ready=0; push+resolve same cycle -> push rejected, occupancy 7.
REQ-037 res_valid on empty queue -> err_underflow=1 held, no upd_valid, counters unchanged.
REQ-038 ext_flush together with mispredicting resolve -> upd_valid=1 next cycle, flush_o=0, queue empty.
REQ-039 rst asserted with 3 entries queued and mispredict pending -> all outputs 0 immediately, next resolve sets err_underflow.
